// File: rtl/des_key_schedule_if.sv
// Subkey-schedule bus between a key-schedule controller (master) and des_key_schedule (slave).
interface des_key_schedule_if;
   logic        start;
   logic        e;
   logic [63:0] k;
   logic [47:0] sk;
   logic [3:0]  sk_round;
   logic        sk_valid;
   logic        sk_ready;
   logic        busy;
   logic        done;
   logic        parity_err;

   modport master (
      output start, e, k, sk_ready,
      input  sk, sk_round, sk_valid, busy, done, parity_err
   );

   modport slave (
      input  start, e, k, sk_ready,
      output sk, sk_round, sk_valid, busy, done, parity_err
   );
endinterface

// File: rtl/des_key_schedule.sv
// DES key schedule: streams the 16 round subkeys in encrypt or decrypt order over a valid/ready bus.
// Optional key byte odd-parity flag enabled by defining DES_KS_PARITY_CHECK_EN.
module des_key_schedule #(
   parameter int unsigned SKIP_PC1 = 0
) (
   input  logic              clk,
   input  logic              rst,
   des_key_schedule_if.slave bus
);

   typedef enum logic [1:0] {IDLE, GEN, FIN} state_t;

   // Table entries are FIPS bit numbers, bit 1 being the MSB of the source vector.
   localparam int PC1_TAB [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2_TAB [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   function automatic logic [55:0] pc1(input logic [63:0] key);
      logic [55:0] r;
      r = '0;
      for (int i = 0; i < 56; i++) r[55-i] = key[64-PC1_TAB[i]];
      return r;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] cd);
      logic [47:0] r;
      r = '0;
      for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_TAB[i]];
      return r;
   endfunction

   function automatic logic [27:0] rot28(input logic [27:0] x, input logic left, input logic two);
      logic [27:0] r;
      case ({left, two})
         2'b11:   r = {x[25:0], x[27:26]};
         2'b10:   r = {x[26:0], x[27]};
         2'b01:   r = {x[1:0], x[27:2]};
         default: r = {x[0], x[27:1]};
      endcase
      return r;
   endfunction

   // Step taken after beat r; encrypt and decrypt share the same list of steps.
   function automatic logic two_step(input logic [3:0] r);
      return !(r == 4'd0 || r == 4'd7 || r == 4'd14);
   endfunction

   state_t      state_q, state_d;
   logic [27:0] c_q, c_d, d_q, d_d;
   logic        enc_q, enc_d;
   logic [3:0]  round_q, round_d;
   logic [47:0] sk_q, sk_d;
   logic        sk_valid_q, sk_valid_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [55:0] cd0;

`ifdef DES_KS_PARITY_CHECK_EN
   logic parity_err_q, parity_err_d;

   function automatic logic parity_bad(input logic [63:0] key);
      logic bad;
      bad = 1'b0;
      for (int b = 0; b < 8; b++) if (!(^key[8*b +: 8])) bad = 1'b1;
      return bad;
   endfunction
`endif

   always_comb begin
      state_d    = state_q;
      c_d        = c_q;
      d_d        = d_q;
      enc_d      = enc_q;
      round_d    = round_q;
      sk_d       = sk_q;
      sk_valid_d = sk_valid_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      cd0        = (SKIP_PC1 != 0) ? bus.k[55:0] : pc1(bus.k);
`ifdef DES_KS_PARITY_CHECK_EN
      parity_err_d = parity_err_q;
`endif
      case (state_q)
         IDLE: begin
            sk_valid_d = 1'b0;
            busy_d     = 1'b0;
            if (bus.start) begin
               state_d    = GEN;
               enc_d      = bus.e;
               round_d    = 4'd0;
               sk_valid_d = 1'b1;
               busy_d     = 1'b1;
               // Encrypt presents K1 first, so the first left step is folded into the load.
               c_d = bus.e ? rot28(cd0[55:28], 1'b1, 1'b0) : cd0[55:28];
               d_d = bus.e ? rot28(cd0[27:0], 1'b1, 1'b0) : cd0[27:0];
               sk_d = pc2({c_d, d_d});
`ifdef DES_KS_PARITY_CHECK_EN
               parity_err_d = parity_bad(bus.k);
`endif
            end
         end
         GEN: begin
            if (sk_valid_q && bus.sk_ready) begin
               if (round_q == 4'd15) begin
                  state_d    = FIN;
                  sk_valid_d = 1'b0;
                  done_d     = 1'b1;
                  round_d    = 4'd0;
                  // Decrypt ends 27 steps right of C0/D0; one more closes the loop.
                  if (!enc_q) begin
                     c_d = rot28(c_q, 1'b0, 1'b0);
                     d_d = rot28(d_q, 1'b0, 1'b0);
                  end
               end else begin
                  round_d = round_q + 4'd1;
                  c_d     = rot28(c_q, enc_q, two_step(round_q));
                  d_d     = rot28(d_q, enc_q, two_step(round_q));
                  sk_d    = pc2({c_d, d_d});
               end
            end
         end
         FIN: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         c_q        <= '0;
         d_q        <= '0;
         enc_q      <= 1'b0;
         round_q    <= '0;
         sk_q       <= '0;
         sk_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef DES_KS_PARITY_CHECK_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         c_q        <= c_d;
         d_q        <= d_d;
         enc_q      <= enc_d;
         round_q    <= round_d;
         sk_q       <= sk_d;
         sk_valid_q <= sk_valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef DES_KS_PARITY_CHECK_EN
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign bus.sk       = sk_q;
   assign bus.sk_round = round_q;
   assign bus.sk_valid = sk_valid_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
`ifdef DES_KS_PARITY_CHECK_EN
   assign bus.parity_err = parity_err_q;
`else
   assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the classic 133457799BBCDFF1 key and its known subkeys.
module tb_des_key_schedule;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   localparam logic [63:0] KEY     = 64'h133457799BBCDFF1;
   localparam logic [63:0] BAD_KEY = 64'h123457799BBCDFF1;

   // Subkeys K1..K16 of KEY.
   logic [47:0] ks [16] = '{
      48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
      48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
      48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
      48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
   };

   always #5 clk = ~clk;

   des_key_schedule_if bus ();

   des_key_schedule #(.SKIP_PC1(0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic pulse_start(input logic [63:0] key, input logic dir);
      bus.k     = key;
      bus.e     = dir;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (bus.sk !== 48'h0) begin failures++; $display("[TB] FAIL reset_sk got=%h exp=0", bus.sk); end
      checks++; if (bus.sk_round !== 4'd0) begin failures++; $display("[TB] FAIL reset_round got=%0d exp=0", bus.sk_round); end
      checks++; if (bus.sk_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", bus.sk_valid); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", bus.done); end
      checks++; if (bus.parity_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_parity got=%b exp=0", bus.parity_err); end
   endtask

   task automatic test_full_run(input logic dir);
      logic [47:0] expv;
      bus.sk_ready = 1'b1;
      pulse_start(KEY, dir);
      for (int i = 0; i < 16; i++) begin
         expv = dir ? ks[i] : ks[15-i];
         checks++; if (bus.sk_valid !== 1'b1) begin failures++; $display("[TB] FAIL run%0b_valid beat=%0d got=%b exp=1", dir, i, bus.sk_valid); end
         checks++; if (bus.sk_round !== 4'(i)) begin failures++; $display("[TB] FAIL run%0b_round beat=%0d got=%0d exp=%0d", dir, i, bus.sk_round, i); end
         checks++; if (bus.sk !== expv) begin failures++; $display("[TB] FAIL run%0b_sk beat=%0d got=%h exp=%h", dir, i, bus.sk, expv); end
         checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin failures++; $display("[TB] FAIL run%0b_busy_done beat=%0d got=%b%b exp=10", dir, i, bus.busy, bus.done); end
         @(negedge clk);
      end
      checks++; if (bus.done !== 1'b1 || bus.sk_valid !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL run%0b_fin done/valid/busy got=%b%b%b exp=101", dir, bus.done, bus.sk_valid, bus.busy); end
      @(negedge clk);
      checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL run%0b_idle done/busy got=%b%b exp=00", dir, bus.done, bus.busy); end
   endtask

   task automatic test_start_ignored();
      bus.sk_ready = 1'b1;
      pulse_start(KEY, 1'b1);
      for (int i = 0; i < 16; i++) begin
         checks++; if (bus.sk_valid !== 1'b1 || bus.sk_round !== 4'(i) || bus.sk !== ks[i]) begin failures++; $display("[TB] FAIL ignore_beat beat=%0d got=%b/%0d/%h exp=1/%0d/%h", i, bus.sk_valid, bus.sk_round, bus.sk, i, ks[i]); end
         if (i == 4) begin bus.start = 1'b1; bus.e = 1'b0; bus.k = BAD_KEY; end
         if (i == 5) bus.start = 1'b0;
         @(negedge clk);
      end
      checks++; if (bus.done !== 1'b1) begin failures++; $display("[TB] FAIL ignore_done got=%b exp=1", bus.done); end
      @(negedge clk);
      checks++; if (bus.sk_valid !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL ignore_idle valid/busy got=%b%b exp=00", bus.sk_valid, bus.busy); end
   endtask

   task automatic test_stalls();
      int  idx = 0;
      bit  done_seen = 0;
      int  stalls = 0;
      bus.sk_ready = 1'b0;
      pulse_start(KEY, 1'b1);
      for (int cyc = 0; cyc < 300 && !done_seen; cyc++) begin
         if (bus.done) begin
            done_seen = 1;
            checks++; if (idx != 16) begin failures++; $display("[TB] FAIL stall_done_early transfers=%0d exp=16", idx); end
         end else if (bus.sk_valid && idx < 16) begin
            checks++; if (bus.sk_round !== 4'(idx) || bus.sk !== ks[idx]) begin failures++; $display("[TB] FAIL stall_beat idx=%0d got=%0d/%h exp=%0d/%h", idx, bus.sk_round, bus.sk, idx, ks[idx]); end
            bus.sk_ready = (cyc == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            if (bus.sk_ready) idx++; else stalls++;
         end else begin
            checks++; failures++;
            $display("[TB] FAIL stall_state valid=%b done=%b idx=%0d", bus.sk_valid, bus.done, idx);
         end
         @(negedge clk);
      end
      checks++; if (!done_seen) begin failures++; $display("[TB] FAIL stall_timeout transfers=%0d exp done", idx); end
      $display("[TB] stall run used %0d stall cycles", stalls);
      bus.sk_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bit saw_done = 0;
      bus.sk_ready = 1'b1;
      pulse_start(KEY, 1'b1);
      repeat (7) @(negedge clk);
      checks++; if (bus.sk_round !== 4'd7) begin failures++; $display("[TB] FAIL rstmid_round got=%0d exp=7", bus.sk_round); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (bus.sk_valid !== 1'b0 || bus.busy !== 1'b0 || bus.sk_round !== 4'd0) begin failures++; $display("[TB] FAIL rstmid_abort valid/busy/round got=%b%b/%0d exp=00/0", bus.sk_valid, bus.busy, bus.sk_round); end
      for (int i = 0; i < 20; i++) begin
         if (bus.done) saw_done = 1;
         @(negedge clk);
      end
      checks++; if (saw_done) begin failures++; $display("[TB] FAIL rstmid_done got=1 exp=0"); end
      pulse_start(KEY, 1'b1);
      checks++; if (bus.sk_valid !== 1'b1 || bus.sk_round !== 4'd0 || bus.sk !== ks[0]) begin failures++; $display("[TB] FAIL rstmid_restart got=%b/%0d/%h exp=1/0/%h", bus.sk_valid, bus.sk_round, bus.sk, ks[0]); end
      repeat (18) @(negedge clk);
      // Reset and start together: reset must win.
      rst = 1'b1;
      pulse_start(KEY, 1'b1);
      rst = 1'b0;
      checks++; if (bus.sk_valid !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_priority valid/busy got=%b%b exp=00", bus.sk_valid, bus.busy); end
      @(negedge clk);
      checks++; if (bus.sk_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_priority_after valid got=%b exp=0", bus.sk_valid); end
   endtask

   task automatic test_parity();
      bus.sk_ready = 1'b1;
`ifdef DES_KS_PARITY_CHECK_EN
      pulse_start(KEY, 1'b1);
      checks++; if (bus.parity_err !== 1'b0) begin failures++; $display("[TB] FAIL parity_good got=%b exp=0", bus.parity_err); end
      repeat (18) @(negedge clk);
      pulse_start(BAD_KEY, 1'b1);
      checks++; if (bus.parity_err !== 1'b1 || bus.sk_valid !== 1'b1) begin failures++; $display("[TB] FAIL parity_bad err/valid got=%b%b exp=11", bus.parity_err, bus.sk_valid); end
      repeat (16) @(negedge clk);
      checks++; if (bus.done !== 1'b1 || bus.parity_err !== 1'b1) begin failures++; $display("[TB] FAIL parity_sticky done/err got=%b%b exp=11", bus.done, bus.parity_err); end
      repeat (2) @(negedge clk);
      pulse_start(KEY, 1'b1);
      checks++; if (bus.parity_err !== 1'b0) begin failures++; $display("[TB] FAIL parity_clear got=%b exp=0", bus.parity_err); end
`else
      pulse_start(BAD_KEY, 1'b1);
      checks++; if (bus.parity_err !== 1'b0) begin failures++; $display("[TB] FAIL parity_off got=%b exp=0", bus.parity_err); end
`endif
      repeat (18) @(negedge clk);
   endtask

   initial begin
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.e        = 1'b0;
      bus.k        = '0;
      bus.sk_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_full_run(1'b1);
      test_full_run(1'b0);
      test_start_ignored();
      test_stalls();
      test_reset_mid();
      test_parity();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
